// File: rtl/mem_bridge_pkg.sv
// Shared types for the data-memory bridge: FSM state encoding and bus size codes.
package mem_bridge_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_ADDR = 2'd1,
    WAIT_DATA = 2'd2,
    DONE      = 2'd3
  } state_t;

  localparam logic [1:0] SIZE_BYTE = 2'd0;
  localparam logic [1:0] SIZE_HALF = 2'd1;
  localparam logic [1:0] SIZE_WORD = 2'd2;

endpackage

// File: rtl/strobe2size.sv
// Maps an M-stage byte strobe onto the bus transfer size code.
module strobe2size
  import mem_bridge_pkg::*;
(
  input  logic [3:0] i_sel,
  output logic [1:0] o_size
);

  always_comb begin
    o_size = SIZE_BYTE;
    case (i_sel)
      4'b1111:          o_size = SIZE_WORD;
      4'b0011, 4'b1100: o_size = SIZE_HALF;
      default:          o_size = SIZE_BYTE;
    endcase
  end

endmodule

// File: rtl/dmem_bridge.sv
// Bridges M-stage loads/stores onto a split addr_ok/data_ok bus, one transaction at a time,
// stalling the pipeline until the response returns.
module dmem_bridge
  import mem_bridge_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic        wr,
  input  logic [3:0]  sel,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic        flush,
  input  logic        pipe_stall,
  output logic [31:0] rdata,
  output logic        stallreq,
  output logic        bus_req,
  output logic        bus_wr,
  output logic [1:0]  bus_size,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  input  logic        bus_addr_ok,
  input  logic        bus_data_ok,
  input  logic [31:0] bus_rdata
);

  state_t      r_state;
  logic        r_wr;
  logic [1:0]  r_size;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [31:0] r_rdata;
  logic        r_discard;

  logic [1:0]  w_size;
  logic        w_idle;
  logic        w_issue;
  logic        w_data_done;

  strobe2size u_strobe2size (
    .i_sel  (sel),
    .o_size (w_size)
  );

  assign w_idle      = (r_state == IDLE);
  assign w_issue     = w_idle & en & ~flush;
  assign w_data_done = (r_state == WAIT_DATA) & bus_data_ok;

  // The request goes out in the same cycle it is seen; later cycles replay the latched copy.
  assign bus_req   = w_issue | (r_state == WAIT_ADDR);
  assign bus_wr    = w_idle ? wr     : r_wr;
  assign bus_size  = w_idle ? w_size : r_size;
  assign bus_addr  = w_idle ? addr   : r_addr;
  assign bus_wdata = w_idle ? wdata  : r_wdata;

  assign stallreq = w_issue | (r_state == WAIT_ADDR) |
                    ((r_state == WAIT_DATA) & ~bus_data_ok);
  assign rdata    = w_data_done ? bus_rdata : r_rdata;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= IDLE;
      r_wr      <= 1'b0;
      r_size    <= SIZE_BYTE;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_rdata   <= '0;
      r_discard <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_issue) begin
            r_wr      <= wr;
            r_size    <= w_size;
            r_addr    <= addr;
            r_wdata   <= wdata;
            r_discard <= 1'b0;
            r_state   <= bus_addr_ok ? WAIT_DATA : WAIT_ADDR;
          end
        end
        WAIT_ADDR: begin
          if (flush) r_discard <= 1'b1;
          if (bus_addr_ok) r_state <= WAIT_DATA;
        end
        WAIT_DATA: begin
          // A flushed transaction still drains, but its response is dropped.
          if (bus_data_ok) begin
            if (r_discard | flush) begin
              r_state <= IDLE;
            end else begin
              r_rdata <= bus_rdata;
              r_state <= pipe_stall ? DONE : IDLE;
            end
          end else if (flush) begin
            r_discard <= 1'b1;
          end
        end
        DONE: begin
          if (!pipe_stall) r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_bridge.sv
// Directed self-checking bench for dmem_bridge.
module tb_dmem_bridge;
  import mem_bridge_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        en, wr, flush, pipe_stall;
  logic [3:0]  sel;
  logic [31:0] addr, wdata;
  logic [31:0] rdata;
  logic        stallreq;
  logic        bus_req, bus_wr;
  logic [1:0]  bus_size;
  logic [31:0] bus_addr, bus_wdata;
  logic        bus_addr_ok, bus_data_ok;
  logic [31:0] bus_rdata;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  always #5 clk = ~clk;

  dmem_bridge dut (
    .clk         (clk),
    .rst         (rst),
    .en          (en),
    .wr          (wr),
    .sel         (sel),
    .addr        (addr),
    .wdata       (wdata),
    .flush       (flush),
    .pipe_stall  (pipe_stall),
    .rdata       (rdata),
    .stallreq    (stallreq),
    .bus_req     (bus_req),
    .bus_wr      (bus_wr),
    .bus_size    (bus_size),
    .bus_addr    (bus_addr),
    .bus_wdata   (bus_wdata),
    .bus_addr_ok (bus_addr_ok),
    .bus_data_ok (bus_data_ok),
    .bus_rdata   (bus_rdata)
  );

  // Advance to just after the next rising edge.
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs;
    en = 0; wr = 0; sel = 4'b0000; addr = '0; wdata = '0;
    flush = 0; pipe_stall = 0;
    bus_addr_ok = 0; bus_data_ok = 0; bus_rdata = '0;
  endtask

  task automatic test_reset;
    idle_inputs();
    rst = 1;
    tick(); tick();
    n_cmp++; if (bus_req !== 1'b0) begin n_err++; $display("FAIL reset_bus_req got=%b exp=0", bus_req); end
    n_cmp++; if (stallreq !== 1'b0) begin n_err++; $display("FAIL reset_stallreq got=%b exp=0", stallreq); end
    n_cmp++; if (rdata !== 32'h0) begin n_err++; $display("FAIL reset_rdata got=%h exp=00000000", rdata); end
    n_cmp++; if (dut.r_state !== IDLE) begin n_err++; $display("FAIL reset_state got=%0d exp=%0d", dut.r_state, IDLE); end
    rst = 0;
    tick();
  endtask

  task automatic test_size_map;
    logic [3:0] sels [7] = '{4'b1111, 4'b0011, 4'b1100, 4'b0001, 4'b0010, 4'b0100, 4'b1000};
    logic [1:0] exps [7] = '{2'd2, 2'd1, 2'd1, 2'd0, 2'd0, 2'd0, 2'd0};
    idle_inputs();
    for (int i = 0; i < 7; i++) begin
      sel = sels[i];
      #1;
      n_cmp++;
      if (bus_size !== exps[i]) begin
        n_err++; $display("FAIL size_map sel=%b got=%0d exp=%0d", sels[i], bus_size, exps[i]);
      end
    end
    n_cmp++; if (bus_req !== 1'b0) begin n_err++; $display("FAIL size_map_no_req got=%b exp=0", bus_req); end
    tick();
  endtask

  task automatic test_word_load;
    idle_inputs();
    en = 1; sel = 4'b1111; addr = 32'h8000_1000; bus_addr_ok = 1;
    #1;
    n_cmp++; if (bus_req !== 1'b1) begin n_err++; $display("FAIL wl_c0_req got=%b exp=1", bus_req); end
    n_cmp++; if (stallreq !== 1'b1) begin n_err++; $display("FAIL wl_c0_stall got=%b exp=1", stallreq); end
    n_cmp++; if (bus_addr !== 32'h8000_1000) begin n_err++; $display("FAIL wl_c0_addr got=%h exp=80001000", bus_addr); end
    n_cmp++; if (bus_size !== 2'd2 || bus_wr !== 1'b0) begin n_err++; $display("FAIL wl_c0_size_wr got=%0d/%b exp=2/0", bus_size, bus_wr); end
    tick();
    bus_addr_ok = 0;
    #1;
    n_cmp++; if (stallreq !== 1'b1) begin n_err++; $display("FAIL wl_c1_stall got=%b exp=1", stallreq); end
    n_cmp++; if (bus_req !== 1'b0) begin n_err++; $display("FAIL wl_c1_req got=%b exp=0", bus_req); end
    tick();
    bus_data_ok = 1; bus_rdata = 32'hDEAD_BEEF;
    #1;
    n_cmp++; if (rdata !== 32'hDEAD_BEEF) begin n_err++; $display("FAIL wl_c2_rdata got=%h exp=deadbeef", rdata); end
    n_cmp++; if (stallreq !== 1'b0) begin n_err++; $display("FAIL wl_c2_stall got=%b exp=0", stallreq); end
    tick();
    idle_inputs();
    #1;
    n_cmp++; if (dut.r_state !== IDLE) begin n_err++; $display("FAIL wl_end_state got=%0d exp=%0d", dut.r_state, IDLE); end
    n_cmp++; if (rdata !== 32'hDEAD_BEEF) begin n_err++; $display("FAIL wl_end_rdata got=%h exp=deadbeef", rdata); end
    tick();
  endtask

  task automatic test_byte_store;
    idle_inputs();
    en = 1; wr = 1; sel = 4'b1000; addr = 32'h8000_0003; wdata = 32'h5A00_0000;
    for (int c = 0; c < 4; c++) begin
      bus_addr_ok = (c == 3);
      #1;
      n_cmp++;
      if (bus_req !== 1'b1 || bus_addr !== 32'h8000_0003 || bus_size !== 2'd0 ||
          bus_wr !== 1'b1 || bus_wdata !== 32'h5A00_0000 || stallreq !== 1'b1) begin
        n_err++;
        $display("FAIL bs_hold c%0d got req=%b addr=%h size=%0d wr=%b wdata=%h stall=%b exp 1/80000003/0/1/5a000000/1",
                 c, bus_req, bus_addr, bus_size, bus_wr, bus_wdata, stallreq);
      end
      tick();
      // Scramble the pipeline inputs; the bus must replay the latched request.
      addr = 32'h1111_2220; wdata = 32'hFFFF_FFFF; sel = 4'b1111; wr = 0;
    end
    bus_addr_ok = 0;
    #1;
    n_cmp++; if (bus_req !== 1'b0 || stallreq !== 1'b1) begin n_err++; $display("FAIL bs_wait got req=%b stall=%b exp 0/1", bus_req, stallreq); end
    tick();
    bus_data_ok = 1; bus_rdata = 32'h0000_0000;
    #1;
    n_cmp++; if (stallreq !== 1'b0) begin n_err++; $display("FAIL bs_release got=%b exp=0", stallreq); end
    tick();
    idle_inputs();
    tick();
  endtask

  task automatic test_pipe_stall;
    idle_inputs();
    en = 1; sel = 4'b1111; addr = 32'h8000_2000; bus_addr_ok = 1;
    tick();
    bus_addr_ok = 0; bus_data_ok = 1; bus_rdata = 32'h1234_5678; pipe_stall = 1;
    #1;
    n_cmp++; if (stallreq !== 1'b0 || rdata !== 32'h1234_5678) begin n_err++; $display("FAIL ps_c1 got stall=%b rdata=%h exp 0/12345678", stallreq, rdata); end
    tick();
    // Stray response and a held instruction must not disturb DONE.
    bus_rdata = 32'hBAD0_BAD0;
    #1;
    n_cmp++; if (dut.r_state !== DONE) begin n_err++; $display("FAIL ps_done_state got=%0d exp=%0d", dut.r_state, DONE); end
    n_cmp++; if (stallreq !== 1'b0 || bus_req !== 1'b0) begin n_err++; $display("FAIL ps_done_out got stall=%b req=%b exp 0/0", stallreq, bus_req); end
    n_cmp++; if (rdata !== 32'h1234_5678) begin n_err++; $display("FAIL ps_done_rdata got=%h exp=12345678", rdata); end
    tick();
    bus_data_ok = 0; pipe_stall = 0;
    #1;
    n_cmp++; if (dut.r_state !== DONE || bus_req !== 1'b0) begin n_err++; $display("FAIL ps_done2 got state=%0d req=%b exp %0d/0", dut.r_state, bus_req, DONE); end
    tick();
    en = 0;
    #1;
    n_cmp++; if (dut.r_state !== IDLE) begin n_err++; $display("FAIL ps_to_idle got=%0d exp=%0d", dut.r_state, IDLE); end
    tick();
  endtask

  task automatic test_flush_drain;
    idle_inputs();
    en = 1; sel = 4'b1111; addr = 32'h8000_3000; bus_addr_ok = 1;
    tick();
    bus_addr_ok = 0; flush = 1;
    #1;
    n_cmp++; if (stallreq !== 1'b1) begin n_err++; $display("FAIL fl_c1_stall got=%b exp=1", stallreq); end
    tick();
    flush = 0; en = 0;
    #1;
    n_cmp++; if (stallreq !== 1'b1) begin n_err++; $display("FAIL fl_c2_stall got=%b exp=1", stallreq); end
    tick();
    bus_data_ok = 1; bus_rdata = 32'hCAFE_F00D; pipe_stall = 1;
    #1;
    n_cmp++; if (stallreq !== 1'b0) begin n_err++; $display("FAIL fl_c3_stall got=%b exp=0", stallreq); end
    tick();
    idle_inputs();
    #1;
    n_cmp++; if (dut.r_state !== IDLE) begin n_err++; $display("FAIL fl_state got=%0d exp=%0d", dut.r_state, IDLE); end
    n_cmp++; if (rdata !== 32'h1234_5678) begin n_err++; $display("FAIL fl_rdata_q got=%h exp=12345678", rdata); end
    tick();
  endtask

  task automatic test_reset_mid;
    idle_inputs();
    en = 1; sel = 4'b0011; addr = 32'h8000_4000;
    tick();
    en = 0;
    #1;
    n_cmp++; if (bus_req !== 1'b1 || bus_size !== 2'd1) begin n_err++; $display("FAIL rm_wait_addr got req=%b size=%0d exp 1/1", bus_req, bus_size); end
    #2 rst = 1;
    #1;
    n_cmp++; if (bus_req !== 1'b0 || stallreq !== 1'b0) begin n_err++; $display("FAIL rm_async got req=%b stall=%b exp 0/0", bus_req, stallreq); end
    n_cmp++; if (dut.r_state !== IDLE || rdata !== 32'h0) begin n_err++; $display("FAIL rm_cleared got state=%0d rdata=%h exp %0d/00000000", dut.r_state, rdata, IDLE); end
    tick();
    rst = 0;
    bus_data_ok = 1; bus_rdata = 32'h7777_7777;
    tick();
    bus_data_ok = 0;
    #1;
    n_cmp++; if (dut.r_state !== IDLE || rdata !== 32'h0) begin n_err++; $display("FAIL rm_stray got state=%0d rdata=%h exp %0d/00000000", dut.r_state, rdata, IDLE); end
    tick();
  endtask

  task automatic test_half_and_flush_idle;
    idle_inputs();
    en = 1; flush = 1; sel = 4'b1111; addr = 32'h8000_5000;
    #1;
    n_cmp++; if (bus_req !== 1'b0 || stallreq !== 1'b0) begin n_err++; $display("FAIL fi_suppress got req=%b stall=%b exp 0/0", bus_req, stallreq); end
    tick();
    n_cmp++; if (dut.r_state !== IDLE) begin n_err++; $display("FAIL fi_state got=%0d exp=%0d", dut.r_state, IDLE); end
    flush = 0; sel = 4'b1100; addr = 32'h8000_5002; bus_addr_ok = 1;
    #1;
    n_cmp++; if (bus_req !== 1'b1 || bus_size !== 2'd1 || bus_addr !== 32'h8000_5002) begin
      n_err++; $display("FAIL half_req got req=%b size=%0d addr=%h exp 1/1/80005002", bus_req, bus_size, bus_addr);
    end
    tick();
    bus_addr_ok = 0; bus_data_ok = 1; bus_rdata = 32'hABCD_0000;
    #1;
    n_cmp++; if (rdata !== 32'hABCD_0000) begin n_err++; $display("FAIL half_rdata got=%h exp=abcd0000", rdata); end
    tick();
    idle_inputs();
    tick();
  endtask

  initial begin
    fork
      begin
        #100000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
      end
    join_none
    test_reset();
    test_size_map();
    test_word_load();
    test_byte_store();
    test_pipe_stall();
    test_flush_drain();
    test_reset_mid();
    test_half_and_flush_idle();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/dmem_bridge.md
DMEM_BRIDGE -- requirements
Module: dmem_bridge

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset; ports are clk and rst.
REQ-002 clk  in  1  rising-edge clock, same clock as the pipeline datapath.
REQ-003 rst  in  1  asynchronous active-high reset.
REQ-004 en  in  1  M-stage data access valid; equals the OR of the exception-masked byte selects.
REQ-005 wr  in  1  1 = store, 0 = load.
REQ-006 sel  in  4  byte strobes from the M stage: 1111, 0011, 1100, 0001, 0010, 0100 or 1000.
REQ-007 addr  in  32  byte address (M-stage ALU result).
REQ-008 wdata  in  32  store data, already lane-aligned.
REQ-009 flush  in  1  M-stage flush (exception).
REQ-010 pipe_stall  in  1  pipeline held by a stall source other than this block.
REQ-011 rdata  out  32  load word returned to the M/W register, unextended.
REQ-012 stallreq  out  1  stallreq_from_mem to the hazard unit.
REQ-013 bus_req  out  1  request valid; bus_wr  out  1; bus_size  out  2; bus_addr  out  32; bus_wdata  out  32.
REQ-014 bus_addr_ok  in  1  request accepted; bus_data_ok  in  1  response complete; bus_rdata  in  32  response data.

Function
REQ-015 FSM states SHALL be IDLE, WAIT_ADDR, WAIT_DATA, DONE.
REQ-016 IDLE: if en & ~flush, bus_req SHALL be 1 in the same cycle, with bus fields taken directly from the inputs; all request fields SHALL be latched.
REQ-017 IDLE transitions: addr_ok=1 -> WAIT_DATA; addr_ok=0 -> WAIT_ADDR.
REQ-018 WAIT_ADDR: bus_req=1, with bus fields from the latched copy; addr_ok -> WAIT_DATA.
REQ-019 WAIT_DATA: bus_req=0; data_ok SHALL be honoured only in this state.
REQ-020 On data_ok, the next state SHALL be DONE if pipe_stall=1, otherwise IDLE.
REQ-021 On data_ok, bus_rdata SHALL be captured into rdata_q.
REQ-022 rdata SHALL equal bus_rdata when in WAIT_DATA with data_ok=1, and rdata_q otherwise.
REQ-023 stallreq SHALL equal (IDLE & en & ~flush) | WAIT_ADDR | (WAIT_DATA & ~data_ok); it SHALL be 0 in DONE.
REQ-024 DONE: no request SHALL be issued; pipe_stall=0 -> IDLE, at the edge where the instruction advances.
REQ-025 bus_size SHALL be 2 for strobe 1111, 1 for 0011 or 1100, and 0 for single-byte strobes.
REQ-026 bus_addr SHALL be addr with bits [1:0] kept unmodified.
REQ-027 bus_wdata SHALL be wdata; bus_wr SHALL be wr.
REQ-028 Flush in WAIT_ADDR or WAIT_DATA: the transaction SHALL drain and stallreq SHALL stay asserted until data_ok.
REQ-029 After a flushed transaction drains, the next state SHALL be IDLE and rdata_q SHALL NOT be updated.
REQ-030 Flush in IDLE SHALL suppress the request.
REQ-031 Minimum load latency SHALL be addr_ok in cycle 0 and data_ok in cycle 1, giving exactly 1 stall cycle.
REQ-032 At most one outstanding transaction SHALL exist.

Reset
REQ-033 Reset SHALL set state=IDLE and bus_req=0.
REQ-034 Reset SHALL clear rdata_q, the latched request fields and the discard flag to 0, so that stallreq=0 and rdata=0.
REQ-035 Reset mid-transaction SHALL abandon the transaction; a data_ok arriving after reset SHALL be ignored in IDLE.

Structure
REQ-036 Package mem_bridge_pkg SHALL hold the state enumeration and the size codes (SIZE_BYTE=0, SIZE_HALF=1, SIZE_WORD=2).
REQ-037 A single combinational sub-module, strobe2size, SHALL map the 4-bit strobe to the 2-bit size.

Verification
REQ-038 Word load, addr=0x80001000, sel=1111, addr_ok in cycle 0, data_ok in cycle 2 -> stallreq=1 for cycles 0-1; in cycle 2, rdata=bus_rdata=0xDEADBEEF and stallreq=0.
REQ-039 Byte store, addr=0x80000003, sel=1000, wdata=0x5A000000, addr_ok delayed 3 cycles -> bus_req held 4 cycles with stable fields (size=0, wr=1), then data_ok releases stallreq.
REQ-040 Data_ok with pipe_stall=1 for 2 cycles -> state DONE, stallreq=0, rdata holds 0x12345678, no new bus_req; IDLE after pipe_stall falls.
REQ-041 Flush asserted in WAIT_DATA -> stallreq stays 1 until data_ok, rdata_q unchanged, state returns to IDLE.
REQ-042 rst pulsed in WAIT_ADDR -> bus_req=0 and state IDLE immediately; a later stray data_ok produces no state change.
REQ-043 Half load with sel=1100 -> bus_size=1; en=1 with flush=1 in IDLE -> bus_req=0 and stallreq=0.
